// File: rtl/sample_log_transmitter_if.sv
// Timer/sample inputs and serial-line outputs of the sample log transmitter.
// The master side drives the timer levels and sample data.
interface sample_log_transmitter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_1minRecord;
  logic             in_5minTransmit;
  logic [WIDTH-1:0] in_SampleData;
  logic             out_TxSerial;
  logic             out_TxBusy;
  logic             out_FrameDone;
  logic             out_BatchDone;
  logic             out_Overflow;
  logic [LW-1:0]    out_Level;

  modport master (
    output in_1minRecord,
    output in_5minTransmit,
    output in_SampleData,
    input  out_TxSerial,
    input  out_TxBusy,
    input  out_FrameDone,
    input  out_BatchDone,
    input  out_Overflow,
    input  out_Level
  );

  modport slave (
    input  in_1minRecord,
    input  in_5minTransmit,
    input  in_SampleData,
    output out_TxSerial,
    output out_TxBusy,
    output out_FrameDone,
    output out_BatchDone,
    output out_Overflow,
    output out_Level
  );
endinterface

// File: rtl/sample_log_transmitter.sv
// Buffers timer-triggered samples in a FIFO and drains them as
// UART-style frames (start, LSB-first data, stop) on transmit events.
module sample_log_transmitter #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int BIT_CYCLES = 16
) (
  input logic in_Clk,
  input logic in_Rst,
  sample_log_transmitter_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  state_t state_q, state_d;

  logic             rec_q, xmt_q;
  logic             rec_ev, xmt_ev;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q, rem_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] sh_q;
  logic             pop, push, accept, bit_end;
  logic             line, busy, fdone, bdone;

  assign rec_ev  = bus.in_1minRecord & ~rec_q;
  assign xmt_ev  = bus.in_5minTransmit & ~xmt_q;
  assign pop     = (state_q == S_LOAD);
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push    = rec_ev & ((level_q != LW'(DEPTH)) | pop);
  assign accept  = xmt_ev & (state_q == S_IDLE)
                 & (level_q != '0);
  assign bit_end = (cnt_q == CW'(BIT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    line    = 1'b1;
    busy    = 1'b1;
    fdone   = 1'b0;
    bdone   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        line = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        line = sh_q[0];
        if (bit_end && bit_q == BW'(WIDTH - 1))
          state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          fdone = 1'b1;
          if (rem_q != '0) begin
            state_d = S_LOAD;
          end else begin
            bdone   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state_q <= S_IDLE;
      rec_q   <= 1'b0;
      xmt_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= bus.in_1minRecord;
      xmt_q   <= bus.in_5minTransmit;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
      if (accept) rem_q <= level_q;
      else if (pop) rem_q <= rem_q - 1'b1;
      if (accept) ovf_q <= 1'b0;
      if (rec_ev && !push) ovf_q <= 1'b1;
      if (state_q == S_START || state_q == S_DATA
          || state_q == S_STOP)
        cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      else
        cnt_q <= '0;
      if (pop) begin
        bit_q <= '0;
        sh_q  <= mem[rd_ptr];
      end else if (state_q == S_DATA && bit_end) begin
        bit_q <= bit_q + 1'b1;
        sh_q  <= sh_q >> 1;
      end
    end
  end

  always_ff @(posedge in_Clk) begin
    if (push) mem[wr_ptr] <= bus.in_SampleData;
  end

  assign bus.out_TxSerial  = line;
  assign bus.out_TxBusy    = busy;
  assign bus.out_FrameDone = fdone;
  assign bus.out_BatchDone = bdone;
  assign bus.out_Overflow  = ovf_q;
  assign bus.out_Level     = level_q;
endmodule

// File: tb/tb_sample_log_transmitter.sv
// Directed bench for sample_log_transmitter (W=8, D=8, BIT_CYCLES=4).
// Frames are checked cycle by cycle against a 41-cycle expected waveform.
module tb_sample_log_transmitter;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int BC = 4;
  localparam int FL = 1 + (W + 2) * BC;

  typedef struct {
    logic [7:0] data;
    logic [3:0] level;
    logic       ovf;
  } rec_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  logic [7:0] exp_q [$];

  sample_log_transmitter_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sample_log_transmitter #(
    .WIDTH(W), .DEPTH(D), .BIT_CYCLES(BC)
  ) dut (
    .in_Clk(clk),
    .in_Rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic record(input logic [7:0] d);
    bus.in_SampleData = d;
    bus.in_1minRecord = 1'b1;
    @(negedge clk);
    bus.in_1minRecord = 1'b0;
    @(negedge clk);
  endtask

  // Sends exp_q as one batch; inj>=0 injects a 0x11 record
  // at that cycle of the first frame.
  task automatic run_batch(input string name, input int inj);
    int n, fd, bd, nbusy;
    logic [FL-1:0] obs, expv;
    n = exp_q.size();
    fd = 0; bd = 0; nbusy = 0;
    bus.in_5minTransmit = 1'b1;
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < FL; c++) begin
        if (f == 0 && c == inj) begin
          bus.in_SampleData = 8'h11;
          bus.in_1minRecord = 1'b1;
        end
        if (f == 0 && c == inj + 2)
          bus.in_1minRecord = 1'b0;
        @(negedge clk);
        obs[c] = bus.out_TxSerial;
        if (!bus.out_TxBusy) nbusy++;
        if (bus.out_FrameDone) fd++;
        if (bus.out_BatchDone) bd++;
      end
      expv = '1;
      for (int i = 1; i <= BC; i++) expv[i] = 1'b0;
      for (int b = 0; b < W; b++)
        for (int k = 0; k < BC; k++)
          expv[1 + BC + b * BC + k] = exp_q[f][b];
      check($sformatf("%s frame%0d", name, f), 64'(obs), 64'(expv));
    end
    check({name, " framedone"}, 64'(fd), 64'(n));
    check({name, " batchdone"}, 64'(bd), 64'd1);
    check({name, " busy gaps"}, 64'(nbusy), 64'd0);
    @(negedge clk);
    check({name, " idle after"},
          {62'd0, bus.out_TxBusy, bus.out_TxSerial}, 64'd1);
    bus.in_5minTransmit = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rec_vec_t tbl [10];
    int nb, pulses;
    for (int i = 0; i < 10; i++) begin
      tbl[i].data  = 8'(i + 1);
      tbl[i].level = (i < 8) ? 4'(i + 1) : 4'd8;
      tbl[i].ovf   = (i >= 8);
    end

    bus.in_1minRecord   = 1'b0;
    bus.in_5minTransmit = 1'b0;
    bus.in_SampleData   = '0;
    @(negedge clk);
    check("reset outputs",
          {bus.out_TxSerial, bus.out_TxBusy, bus.out_FrameDone,
           bus.out_BatchDone, bus.out_Overflow, bus.out_Level},
          64'h100);
    rst = 1'b0;
    @(negedge clk);

    // 1: three samples, one batch
    record(8'hA5);
    check("t1 level1", 64'(bus.out_Level), 64'd1);
    record(8'h3C);
    record(8'hFF);
    check("t1 level3", 64'(bus.out_Level), 64'd3);
    exp_q = {8'hA5, 8'h3C, 8'hFF};
    run_batch("t1", -10);
    check("t1 level end", 64'(bus.out_Level), 64'd0);

    // 2: overflow table
    for (int i = 0; i < 10; i++) begin
      bus.in_SampleData = tbl[i].data;
      bus.in_1minRecord = 1'b1;
      @(negedge clk);
      check($sformatf("t2 rec%0d", i),
            {59'd0, bus.out_Overflow, bus.out_Level},
            {59'd0, tbl[i].ovf, tbl[i].level});
      bus.in_1minRecord = 1'b0;
      @(negedge clk);
    end
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(tbl[i].data);
    run_batch("t2", -10);
    check("t2 ovf cleared",
          {59'd0, bus.out_Overflow, bus.out_Level}, 64'd0);

    // 3: transmit with empty FIFO
    bus.in_5minTransmit = 1'b1;
    nb = 0; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_TxBusy || !bus.out_TxSerial) nb++;
      if (bus.out_FrameDone || bus.out_BatchDone) pulses++;
    end
    check("t3 no activity", 64'(nb), 64'd0);
    check("t3 no pulses", 64'(pulses), 64'd0);
    bus.in_5minTransmit = 1'b0;
    @(negedge clk);

    // 4: long record level
    bus.in_SampleData = 8'h77;
    bus.in_1minRecord = 1'b1;
    repeat (500) @(negedge clk);
    bus.in_1minRecord = 1'b0;
    @(negedge clk);
    check("t4 one sample", 64'(bus.out_Level), 64'd1);

    // 5: record during a 2-frame batch
    record(8'h22);
    exp_q = {8'h77, 8'h22};
    run_batch("t5", 10);
    check("t5 level after", 64'(bus.out_Level), 64'd1);

    // 6: reset mid-DATA
    bus.in_5minTransmit = 1'b1;
    repeat (16) @(negedge clk);
    check("t6 line low pre", 64'(bus.out_TxBusy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6 reset async",
          {58'd0, bus.out_TxSerial, bus.out_TxBusy, bus.out_Level},
          {58'd0, 1'b1, 1'b0, 4'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    record(8'h5A);
    nb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_TxBusy) nb++;
    end
    check("t6 held high no send", 64'(nb), 64'd0);
    bus.in_5minTransmit = 1'b0;
    @(negedge clk);
    exp_q = {8'h5A};
    run_batch("t6", -10);
    check("t6 level end", 64'(bus.out_Level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
